adc_read: RTL and testbench
===========================

Name: adc_read

Overview:
- SPI master that continuously scans a 4-channel, 12-bit serial ADC.
- Reduces each sample to its top 8 bits and packs the four bytes into one word for the AXI GPIO input channel (ctrl_i) read by processing system 7.
- Read-direction counterpart of the DP-writing SPI controller. It shares sclk and rst_n with that controller.
- Byte layout, MSB to LSB: rudder control (ch3), main engine (ch2), sub engine (ch1), rudder indication (ch0).

Parameters:
- IDLE_CYC, 2: sclk cycles cs_n is held high between frames; legal range 1..15.
- NCH, 4: number of channels scanned; fixed at 4 because the packed output is 32 bits.

Ports:
- sclk, input, 1: system and SPI clock. All state updates on the rising edge; the ADC sees the same sclk.
- rst_n, input, 1: asynchronous active-low reset.
- en, input, 1: scan enable, sampled only in IDLE.
- sdi, input, 1: ADC DOUT.
- sdo, output, 1: ADC DIN (channel address).
- cs_n, output, 1: ADC chip select, active low.
- ctrl_i, output, 32: packed bytes {ch3, ch2, ch1, ch0}.
- ctrl_vld, output, 1: one-cycle pulse when a full 4-channel sweep has been written.

Behaviour:
- Reset (async assert, sync release):
  - cs_n=1, sdo=0, ctrl_i=32'h0, ctrl_vld=0.
  - state=IDLE, idle counter=0, bit counter b=0, channel ch=0, shift register=0.
  - Reset mid-frame raises cs_n immediately and discards the partial sample; ctrl_i is cleared.
- IDLE:
  - cs_n=1, sdo=0.
  - Idle counter increments each cycle, saturating at IDLE_CYC.
  - When counter==IDLE_CYC and en=1: clear counter, b=0, go to XFER. cs_n goes low on this edge.
  - If en=0, remain in IDLE with cs_n high indefinitely; ch is preserved.
- XFER (16 cycles, b=0..15, b increments each edge):
  - sdo = ch[1] while b==2, ch[0] while b==3, otherwise 0. sdo is registered and changes on the edge that enters each bit.
  - On the rising edge that ends bit b, for b=4..15: shift register <= {sr[10:0], sdi}, MSB first, 12 captures total.
  - On the edge ending b==15 the 12-bit sample is {sr[10:0], sdi}. On that same edge:
    - byte ch of ctrl_i <= sample[11:4], i.e. ctrl_i[8*ch+7 : 8*ch]; other bytes unchanged.
    - ch <= ch+1, wrapping 3 to 0.
    - state <= IDLE, cs_n <= 1, sdo <= 0, idle counter <= 0.
    - If ch==3, ctrl_vld <= 1 for exactly this one following cycle.
- Timing:
  - Frame period = 16 + IDLE_CYC + 1 cycles, counting the IDLE exit edge.
  - Default sweep = 4 × 19 = 76 cycles.
  - Byte update latency: ctrl_i changes on the edge where cs_n rises.
- en behaviour:
  - en deasserted during XFER has no effect; the frame completes.
  - The scan stops at the next IDLE and resumes from the same ch when en returns.
- ctrl_i holds its last values between updates. Bytes are never partially written and never torn within a byte.
- ctrl_vld is 0 at all other times. It never asserts after an incomplete sweep or on ch0..ch2 updates.
- Arithmetic:
  - b is 4-bit and stops at 15.
  - ch is 2-bit with natural wrap.
  - The low nibble sample[3:0] is discarded with no rounding.

Test Plan:
1. Reset then en=1. ADC model returns 12'hABC, 12'h123, 12'h7F0, 12'hFFF for ch0..3.
   -> After the first sweep ctrl_i=32'hFF7F12AB.
   -> ctrl_vld pulses once, at cycle 76 after reset release.
   -> cs_n low exactly 16 cycles per frame, high 3 cycles between frames.
2. Monitor sdo across a sweep.
   -> Address bits at b=2,3 read 00, 01, 10, 11 for consecutive frames; sdo=0 elsewhere.
3. en dropped mid-frame (ch1, b=7).
   -> Frame completes and ctrl_i[15:8] is updated.
   -> cs_n stays high while en=0.
   -> After en=1, the next frame addresses ch2.
4. rst_n asserted at ch2, b=9.
   -> cs_n=1 and ctrl_i=0 the same instant.
   -> After release, the first frame addresses ch0 and there is no ctrl_vld until a full new sweep completes.
5. ADC values change between sweeps (ch0 0x000 then 0xFFF).
   -> ctrl_i[7:0] goes 0x00 then 0xFF.
   -> Other bytes change only on their own frame edges.
   -> ctrl_vld pulses once per 76 cycles.
6. IDLE_CYC=1.
   -> Frame period 18 cycles; cs_n high for 2 cycles between frames; sampled values unchanged from scenario 1.

Source files
------------

// File: rtl/adc_read.sv
// adc_read: SPI master scanning a 4-channel 12-bit ADC into packed bytes {ch3,ch2,ch1,ch0}; ports sclk/rst_n/en/sdi in, sdo/cs_n/ctrl_i/ctrl_vld out
module adc_read #(
  parameter int IDLE_CYC = 2,
  parameter int NCH = 4
) (
  input  logic        sclk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        sdi,
  output logic        sdo,
  output logic        cs_n,
  output logic [31:0] ctrl_i,
  output logic        ctrl_vld
);
  typedef enum logic {IDLE, XFER} state_t;
  state_t state_q, state_d;
  logic [3:0] icnt_q, icnt_d, b_q, b_d;
  logic [1:0] ch_q, ch_d;
  logic [10:0] sr_q, sr_d;
  logic sdo_q, sdo_d, cs_n_q, cs_n_d, vld_q, vld_d;
  logic [31:0] ctrl_q, ctrl_d;
  always_comb begin
    state_d = state_q;
    icnt_d = icnt_q;
    b_d = b_q;
    ch_d = ch_q;
    sr_d = sr_q;
    sdo_d = 1'b0;
    cs_n_d = cs_n_q;
    ctrl_d = ctrl_q;
    vld_d = 1'b0;
    if (state_q == IDLE) begin
      icnt_d = icnt_q == 4'(IDLE_CYC) ? icnt_q : icnt_q + 4'd1;
      if (icnt_q == 4'(IDLE_CYC) && en) begin
        state_d = XFER;
        icnt_d = 4'd0;
        b_d = 4'd0;
        cs_n_d = 1'b0;
      end
    end else begin
      b_d = b_q == 4'd15 ? b_q : b_q + 4'd1;
      sdo_d = b_d == 4'd2 ? ch_q[1] : b_d == 4'd3 ? ch_q[0] : 1'b0;
      if (b_q >= 4'd4) sr_d = {sr_q[9:0], sdi};
      if (b_q == 4'd15) begin
        ctrl_d[{ch_q, 3'b000} +: 8] = sr_q[10:3];
        ch_d = ch_q == 2'(NCH - 1) ? 2'd0 : ch_q + 2'd1;
        vld_d = ch_q == 2'(NCH - 1);
        state_d = IDLE;
        cs_n_d = 1'b1;
        sdo_d = 1'b0;
        icnt_d = 4'd0;
      end
    end
  end
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      icnt_q <= 4'd0;
      b_q <= 4'd0;
      ch_q <= 2'd0;
      sr_q <= 11'd0;
      sdo_q <= 1'b0;
      cs_n_q <= 1'b1;
      ctrl_q <= 32'h0;
      vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      icnt_q <= icnt_d;
      b_q <= b_d;
      ch_q <= ch_d;
      sr_q <= sr_d;
      sdo_q <= sdo_d;
      cs_n_q <= cs_n_d;
      ctrl_q <= ctrl_d;
      vld_q <= vld_d;
    end
  end
  assign sdo = sdo_q;
  assign cs_n = cs_n_q;
  assign ctrl_i = ctrl_q;
  assign ctrl_vld = vld_q;
endmodule

// File: tb/tb_adc_read.sv
// tb_adc_read: randomized scoreboard bench for adc_read at IDLE_CYC=2 and IDLE_CYC=1
module tb_adc_read;
  logic sclk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic [1:0] sdi = 2'b00, sdo, cs_n, vld;
  logic [31:0] ctrl [2];
  logic [11:0] adc_val [4];
  int checks = 0, failures = 0, tmo = 0, tseen = 0;
  typedef struct {logic [31:0] w; logic v; logic [1:0] ch; logic [1:0] a;} exp_t;
  exp_t q [2][$];
  always #5 sclk = ~sclk;
  for (genvar g = 0; g < 2; g++) begin : gi
    adc_read #(.IDLE_CYC(g == 0 ? 2 : 1)) u (
      .sclk(sclk), .rst_n(rst_n), .en(en), .sdi(sdi[g]), .sdo(sdo[g]),
      .cs_n(cs_n[g]), .ctrl_i(ctrl[g]), .ctrl_vld(vld[g]));
  end
  function automatic int icf(input int i);
    return i == 0 ? 2 : 1;
  endfunction
  int bc [2];
  logic [1:0] mch [2], addr [2];
  logic [31:0] mw [2];
  logic [11:0] samp [2], expv [2];
  always @(negedge sclk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        bc[i] = 0;
        mch[i] = 2'd0;
        mw[i] = 32'h0;
        sdi[i] = 1'b0;
      end else if (cs_n[i]) begin
        bc[i] = 0;
        sdi[i] = 1'b0;
      end else begin
        if (bc[i] == 2) addr[i][1] = sdo[i];
        if (bc[i] == 3) begin
          addr[i][0] = sdo[i];
          samp[i] = adc_val[addr[i]];
          expv[i] = adc_val[mch[i]];
        end
        sdi[i] = bc[i] >= 4 ? samp[i][15 - bc[i]] : 1'b0;
        if (bc[i] == 15) begin
          mw[i] = (mw[i] & ~(32'hFF << (8 * mch[i]))) | (32'(expv[i] / 16) << (8 * mch[i]));
          q[i].push_back('{mw[i], mch[i] == 2'd3, mch[i], addr[i]});
          mch[i] = mch[i] + 2'd1;
        end
        bc[i]++;
      end
    end
  end
  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask
  int lr [2], hr [2], cyc [2];
  logic pcs [2];
  bit vs [2], sf [2], eok [2];
  logic [31:0] lc [2];
  exp_t e;
  always @(negedge sclk) begin
    if (tmo != tseen) begin
      chk(tmo == tseen, "wait_timeout", 32'(tmo), 32'(tseen));
      tseen = tmo;
    end
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        chk({cs_n[i], sdo[i], vld[i]} === 3'b100, "reset_pins", 32'({cs_n[i], sdo[i], vld[i]}), 32'b100);
        chk(ctrl[i] === 32'h0, "reset_ctrl", ctrl[i], 32'h0);
        q[i].delete();
        lr[i] = 0;
        hr[i] = 0;
        cyc[i] = 0;
        vs[i] = 0;
        sf[i] = 0;
        eok[i] = 1;
        lc[i] = 32'h0;
        pcs[i] = 1'b1;
      end else begin
        cyc[i]++;
        if (!cs_n[i]) begin
          lr[i]++;
          if (pcs[i]) begin
            chk(en === 1'b1, "start_needs_en", 32'(en), 32'd1);
            if (sf[i] && eok[i]) chk(hr[i] == icf(i) + 1, "gap_len", 32'(hr[i]), 32'(icf(i) + 1));
          end
          if (lr[i] != 3 && lr[i] != 4) chk(sdo[i] === 1'b0, "sdo_nonaddr", 32'(sdo[i]), 32'd0);
          chk(vld[i] === 1'b0, "vld_quiet", 32'(vld[i]), 32'd0);
          chk(ctrl[i] === lc[i], "ctrl_hold", ctrl[i], lc[i]);
          hr[i] = 0;
        end else begin
          if (!pcs[i]) begin
            chk(lr[i] == 16, "frame_len", 32'(lr[i]), 32'd16);
            chk(q[i].size() != 0, "queue_empty", 32'(q[i].size()), 32'd1);
            if (q[i].size() != 0) begin
              e = q[i].pop_front();
              chk(ctrl[i] === e.w, "ctrl_word", ctrl[i], e.w);
              chk(vld[i] === e.v, "vld_on_frame", 32'(vld[i]), 32'(e.v));
              chk(e.a == e.ch, "frame_addr", 32'(e.a), 32'(e.ch));
            end
            if (vld[i] && !vs[i]) begin
              chk(cyc[i] == 4 * (17 + icf(i)), "first_sweep_cycle", 32'(cyc[i]), 32'(4 * (17 + icf(i))));
              vs[i] = 1;
            end
            lc[i] = ctrl[i];
            sf[i] = 1;
            eok[i] = 1;
            lr[i] = 0;
          end else begin
            chk(vld[i] === 1'b0, "vld_quiet", 32'(vld[i]), 32'd0);
            chk(ctrl[i] === lc[i], "ctrl_hold", ctrl[i], lc[i]);
          end
          chk(sdo[i] === 1'b0, "sdo_idle", 32'(sdo[i]), 32'd0);
          if (!en) eok[i] = 0;
          hr[i]++;
        end
        pcs[i] = cs_n[i];
      end
    end
  end
  initial begin
    adc_val[0] = 12'hABC;
    adc_val[1] = 12'h123;
    adc_val[2] = 12'h7F0;
    adc_val[3] = 12'hFFF;
    repeat (3) @(negedge sclk);
    en = 1'b1;
    @(negedge sclk);
    #2 rst_n = 1'b1;
    repeat (160) @(negedge sclk);
    for (int k = 0; k < 300 && !(mch[0] == 2'd1 && bc[0] == 7); k++) @(negedge sclk);
    if (!(mch[0] == 2'd1 && bc[0] == 7)) tmo++;
    #2 en = 1'b0;
    repeat (60) @(negedge sclk);
    #2 en = 1'b1;
    repeat (100) @(negedge sclk);
    for (int k = 0; k < 300 && !(mch[0] == 2'd2 && bc[0] == 9); k++) @(negedge sclk);
    if (!(mch[0] == 2'd2 && bc[0] == 9)) tmo++;
    @(posedge sclk);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge sclk);
    #2 rst_n = 1'b1;
    repeat (100) @(negedge sclk);
    for (int s = 0; s < 6; s++) begin
      adc_val[0] = (s % 2) != 0 ? 12'hFFF : 12'h000;
      for (int j = 1; j < 4; j++) adc_val[j] = 12'($urandom);
      repeat (76) @(negedge sclk);
    end
    repeat (5) @(negedge sclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
